dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 512, meaning the number of 64-bit backing words; the valid byte range is [0, MEM_WORDS*8).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to response; legal range 1..15.
REQ-003 clk_i  in  1  clock; rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 mem_req_valid_i  in  1  request valid.
REQ-005 mem_req_cmd_i  in  5  command: 0 load, 1 store, 4 swap, 6 lr, 7 sc, 8 add, 9 xor, 10 or, 11 and, 12 min, 13 max, 14 minu, 15 maxu.
REQ-006 mem_op_type_i  in  4  bit 2 = unsigned; bits 1:0 = size (0 byte, 1 half, 2 word, 3 dword); bit 3 ignored.
REQ-007 mem_req_bits_addr_i  in  40  byte address.
REQ-008 mem_req_bits_data_i  in  64  store/AMO operand (LSB-aligned).
REQ-009 mem_req_bits_tag_i  in  8  tag returned with the response.
REQ-010 mem_req_bits_kill_i  in  1  abort of the in-flight request.
REQ-011 mem_req_invalidate_lr_i  in  1  clear the LR reservation.
REQ-012 dmem_req_ready_o  out  1  able to accept a request.
REQ-013 dmem_resp_valid_o  out  1  one-cycle response pulse.
REQ-014 dmem_resp_bits_data_o  out 64; dmem_resp_bits_tag_o  out 8.
REQ-015 dmem_resp_bits_nack_o  out 1; dmem_resp_bits_replay_o  out 1, tied to 0.
REQ-016 dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o, dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o  out  1 each  exception pulses.

Function
REQ-017 States: IDLE, WAIT, RESP; dmem_req_ready_o SHALL be 1 only in IDLE.
REQ-018 Acceptance occurs when valid & ready: cmd, op_type, addr, data and tag are latched, a latency counter is loaded with LATENCY-1, and the FSM goes to WAIT.
REQ-019 Misaligned means addr low bits are nonzero for the size: half checks addr[0], word checks addr[1:0], dword checks addr[2:0]; a page fault is addr >= MEM_WORDS*8.
REQ-020 On a faulting accepted request, the FSM SHALL pulse xcpt for exactly the first WAIT cycle, then return to IDLE with no resp_valid and no memory or reservation change.
  - Load/lr faults drive the _ld flag; store/sc/AMO faults drive the _st flag.
  - Misalignment takes priority over page fault.
REQ-021 An unsupported cmd SHALL pulse nack in the first WAIT cycle and return to IDLE with no side effects.
  - AMO/lr/sc with size 0 or 1 is treated as unsupported.
REQ-022 In WAIT, the counter SHALL decrement each cycle; when it reaches 0 the FSM enters RESP.
  - resp_valid is asserted in the RESP cycle, exactly LATENCY cycles after the acceptance edge.
REQ-023 kill_i sampled high in any WAIT cycle (including the xcpt cycle) or in the RESP cycle SHALL abort the request.
  - No resp_valid is issued, no write occurs, and the FSM goes to IDLE next cycle.
REQ-024 RESP lasts one cycle and then returns to IDLE; resp_tag equals the latched tag.
REQ-025 Memory writes (store, sc-success, AMO) SHALL commit only on the RESP edge, using byte enables derived from size and addr[2:0].
REQ-026 Load data SHALL be the addressed field shifted to LSB, sign-extended unless unsigned; a store response returns data 0.
REQ-027 lr returns the loaded value and sets reservation {valid=1, dword address}.
REQ-028 sc SHALL write and return 0 if the reservation is valid and matches the dword address; otherwise it returns 1 with no write.
  - sc clears the reservation in either case.
REQ-029 An AMO returns the old value (word results sign-extended) and writes op(old, operand) at the operation size.
  - min/max are signed; minu/maxu are unsigned.
REQ-030 A plain store or AMO to the reserved dword, or invalidate_lr_i in any cycle, SHALL clear the reservation.
  - invalidate_lr_i takes priority over a same-cycle lr set.
REQ-031 valid held high outside IDLE SHALL be ignored; the same request is re-accepted only when it is seen again in IDLE.

Reset
REQ-032 While rstn_i is low: FSM=IDLE, counter=0, reservation invalid, ready=1, and all other outputs 0 (data and tag 0).
REQ-033 Assertion of reset mid-operation SHALL discard the request without a memory write; memory contents are not reset.

Verification
REQ-034 Dword store 0x1122334455667788 to 0x40, then ld 0x40 with LATENCY=2 -> ready low 2 cycles, resp_valid 2 cycles after acceptance, data 0x1122334455667788, tag echoed.
REQ-035 lb unsigned 0x47 -> data 0x11; lb signed on 0x80-valued byte -> 0xFFFFFFFFFFFFFF80.
REQ-036 lw at 0x42 -> ma_ld pulses 1 cycle after acceptance, no resp_valid; sd at 0x1000 (MEM_WORDS=512) -> pf_st pulse, memory unchanged.
REQ-037 lr.d 0x40 then sc.d 0x40 -> sc data 0; repeat sc -> data 1; lr then invalidate_lr_i then sc -> data 1.
REQ-038 amoadd.w 0x48 (old 0x7FFFFFFF, operand 1) -> resp 0x7FFFFFFF, memory word 0x80000000; amomaxu with operand 0 leaves the word unchanged.
REQ-039 Store with kill_i high in its WAIT cycle -> no resp_valid, a following load returns the old data; reset asserted mid-WAIT -> ready=1 and outputs 0 while reset is low.

Source files
------------

// File: rtl/dmem_responder_if.sv
// ============================================================================
// dmem_responder_if : request/response bundle between a core LSU and the
//                     dmem_responder backing memory.  Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;
  logic        mem_req_valid_i;
  logic [4:0]  mem_req_cmd_i;
  logic [3:0]  mem_op_type_i;
  logic [39:0] mem_req_bits_addr_i;
  logic [63:0] mem_req_bits_data_i;
  logic [7:0]  mem_req_bits_tag_i;
  logic        mem_req_bits_kill_i;
  logic        mem_req_invalidate_lr_i;
  logic        dmem_req_ready_o;
  logic        dmem_resp_valid_o;
  logic [63:0] dmem_resp_bits_data_o;
  logic [7:0]  dmem_resp_bits_tag_o;
  logic        dmem_resp_bits_nack_o;
  logic        dmem_resp_bits_replay_o;
  logic        dmem_xcpt_ma_ld_o;
  logic        dmem_xcpt_ma_st_o;
  logic        dmem_xcpt_pf_ld_o;
  logic        dmem_xcpt_pf_st_o;

  modport slave (
    input  mem_req_valid_i, mem_req_cmd_i, mem_op_type_i, mem_req_bits_addr_i,
           mem_req_bits_data_i, mem_req_bits_tag_i, mem_req_bits_kill_i,
           mem_req_invalidate_lr_i,
    output dmem_req_ready_o, dmem_resp_valid_o, dmem_resp_bits_data_o,
           dmem_resp_bits_tag_o, dmem_resp_bits_nack_o, dmem_resp_bits_replay_o,
           dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o, dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o
  );

  modport master (
    output mem_req_valid_i, mem_req_cmd_i, mem_op_type_i, mem_req_bits_addr_i,
           mem_req_bits_data_i, mem_req_bits_tag_i, mem_req_bits_kill_i,
           mem_req_invalidate_lr_i,
    input  dmem_req_ready_o, dmem_resp_valid_o, dmem_resp_bits_data_o,
           dmem_resp_bits_tag_o, dmem_resp_bits_nack_o, dmem_resp_bits_replay_o,
           dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o, dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : single-outstanding data memory model with fixed latency,
//                  loads/stores, LR/SC and AMOs.  Rev 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int MEM_WORDS = 512,
  parameter int LATENCY   = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  dmem_responder_if.slave bus
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [40:0] MEM_BYTES = 41'(MEM_WORDS) * 41'd8;

  localparam logic [4:0] CMD_LD   = 5'd0,  CMD_ST  = 5'd1,  CMD_SWAP = 5'd4;
  localparam logic [4:0] CMD_LR   = 5'd6,  CMD_SC  = 5'd7,  CMD_ADD  = 5'd8;
  localparam logic [4:0] CMD_XOR  = 5'd9,  CMD_OR  = 5'd10, CMD_AND  = 5'd11;
  localparam logic [4:0] CMD_MIN  = 5'd12, CMD_MAX = 5'd13, CMD_MINU = 5'd14;
  localparam logic [4:0] CMD_MAXU = 5'd15;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [2:0]  op_q, op_d;
  logic [39:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  tag_q, tag_d;
  logic        res_valid_q, res_valid_d;
  logic [36:0] res_addr_q, res_addr_d;

  logic [63:0] mem_q [MEM_WORDS];

  function automatic logic [63:0] ext_field(input logic [63:0] v, input logic [1:0] sz,
                                            input logic sgn);
    logic [63:0] r;
    case (sz)
      2'd0:    r = {{56{sgn & v[7]}},  v[7:0]};
      2'd1:    r = {{48{sgn & v[15]}}, v[15:0]};
      2'd2:    r = {{32{sgn & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  logic [1:0]       size;
  logic [2:0]       off;
  logic [5:0]       bit_off;
  logic [IDX_W-1:0] idx;
  logic             is_ld, is_st, is_lr, is_sc, is_amo, ld_kind;
  logic             unsup, misal, pf, sc_ok, res_hit, commit, wr_en;
  logic [7:0]       be;
  logic [63:0]      wmask, old_dw, old_sh, a_s, b_s, a_u, b_u, amo_res, new_field, wdata;

  assign size    = op_q[1:0];
  assign off     = addr_q[2:0];
  assign bit_off = {off, 3'b000};
  assign idx     = addr_q[3 +: IDX_W];
  assign old_dw  = mem_q[idx];
  assign old_sh  = old_dw >> bit_off;

  assign is_ld   = (cmd_q == CMD_LD);
  assign is_st   = (cmd_q == CMD_ST);
  assign is_lr   = (cmd_q == CMD_LR);
  assign is_sc   = (cmd_q == CMD_SC);
  assign is_amo  = (cmd_q == CMD_SWAP) || ((cmd_q >= CMD_ADD) && (cmd_q <= CMD_MAXU));
  assign ld_kind = is_ld || is_lr;
  assign unsup   = !(is_ld || is_st || is_lr || is_sc || is_amo) ||
                   ((is_lr || is_sc || is_amo) && !size[1]);
  assign misal   = (size == 2'd1) ? addr_q[0] :
                   (size == 2'd2) ? |addr_q[1:0] :
                   (size == 2'd3) ? |addr_q[2:0] : 1'b0;
  assign pf      = {1'b0, addr_q} >= MEM_BYTES;
  assign res_hit = res_valid_q && (res_addr_q == addr_q[39:3]);
  assign sc_ok   = res_hit;

  // Operands are widened both ways so signed and unsigned compares work at any size.
  assign a_s = ext_field(old_sh, size, 1'b1);
  assign b_s = ext_field(data_q, size, 1'b1);
  assign a_u = ext_field(old_sh, size, 1'b0);
  assign b_u = ext_field(data_q, size, 1'b0);

  always_comb begin
    amo_res = b_s;
    case (cmd_q)
      CMD_ADD:  amo_res = a_s + b_s;
      CMD_XOR:  amo_res = a_s ^ b_s;
      CMD_OR:   amo_res = a_s | b_s;
      CMD_AND:  amo_res = a_s & b_s;
      CMD_MIN:  amo_res = ($signed(a_s) < $signed(b_s)) ? a_s : b_s;
      CMD_MAX:  amo_res = ($signed(a_s) > $signed(b_s)) ? a_s : b_s;
      CMD_MINU: amo_res = (a_u < b_u) ? a_u : b_u;
      CMD_MAXU: amo_res = (a_u > b_u) ? a_u : b_u;
      default:  amo_res = b_s;
    endcase
  end

  always_comb begin
    case (size)
      2'd0:    be = 8'h01 << off;
      2'd1:    be = 8'h03 << off;
      2'd2:    be = 8'h0F << off;
      default: be = 8'hFF;
    endcase
    for (int i = 0; i < 8; i++) wmask[i*8 +: 8] = {8{be[i]}};
  end

  assign new_field = is_amo ? amo_res : data_q;
  assign wdata     = (old_dw & ~wmask) | ((new_field << bit_off) & wmask);
  assign commit    = (state_q == RESP) && !bus.mem_req_bits_kill_i;
  assign wr_en     = commit && (is_st || is_amo || (is_sc && sc_ok));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    cmd_d   = cmd_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tag_d   = tag_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_valid_i) begin
          cmd_d   = bus.mem_req_cmd_i;
          op_d    = bus.mem_op_type_i[2:0];
          addr_d  = bus.mem_req_bits_addr_i;
          data_d  = bus.mem_req_bits_data_i;
          tag_d   = bus.mem_req_bits_tag_i;
          cnt_d   = 4'(LATENCY - 1);
          first_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        first_d = 1'b0;
        if (bus.mem_req_bits_kill_i || (first_q && (unsup || misal || pf))) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Invalidation is applied last so it wins over an lr committing in the same cycle.
  always_comb begin
    res_valid_d = res_valid_q;
    res_addr_d  = res_addr_q;
    if (commit) begin
      if (is_lr) begin
        res_valid_d = 1'b1;
        res_addr_d  = addr_q[39:3];
      end
      if (is_sc || ((is_st || is_amo) && res_hit)) res_valid_d = 1'b0;
    end
    if (bus.mem_req_invalidate_lr_i) res_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      first_q     <= 1'b0;
      cmd_q       <= 5'd0;
      op_q        <= 3'd0;
      addr_q      <= 40'd0;
      data_q      <= 64'd0;
      tag_q       <= 8'd0;
      res_valid_q <= 1'b0;
      res_addr_q  <= 37'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      cmd_q       <= cmd_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[idx] <= wdata;
  end

  logic        xcpt_cycle;
  logic [63:0] resp_data;

  assign xcpt_cycle = (state_q == WAIT) && first_q && !unsup;

  always_comb begin
    resp_data = 64'd0;
    if (ld_kind)     resp_data = ext_field(old_sh, size, !op_q[2]);
    else if (is_sc)  resp_data = {63'd0, !sc_ok};
    else if (is_amo) resp_data = ext_field(old_sh, size, 1'b1);
  end

  assign bus.dmem_req_ready_o        = (state_q == IDLE);
  assign bus.dmem_resp_valid_o       = commit;
  assign bus.dmem_resp_bits_data_o   = commit ? resp_data : 64'd0;
  assign bus.dmem_resp_bits_tag_o    = commit ? tag_q : 8'd0;
  assign bus.dmem_resp_bits_nack_o   = (state_q == WAIT) && first_q && unsup;
  assign bus.dmem_resp_bits_replay_o = 1'b0;
  assign bus.dmem_xcpt_ma_ld_o       = xcpt_cycle && misal && ld_kind;
  assign bus.dmem_xcpt_ma_st_o       = xcpt_cycle && misal && !ld_kind;
  assign bus.dmem_xcpt_pf_ld_o       = xcpt_cycle && !misal && pf && ld_kind;
  assign bus.dmem_xcpt_pf_st_o       = xcpt_cycle && !misal && pf && !ld_kind;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : directed scoreboard bench for dmem_responder.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int LAT = 2;
  localparam logic [2:0] K_RESP = 3'd0, K_MALD = 3'd1, K_MAST = 3'd2;
  localparam logic [2:0] K_PFLD = 3'd3, K_PFST = 3'd4, K_NACK = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [63:0] data;
    logic [7:0]  tag;
    logic [31:0] cyc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] cyc = 32'd0;
  int          errs = 0;
  int          checks = 0;
  logic [7:0]  next_tag = 8'd1;
  exp_t        sb_q[$];

  dmem_responder_if bus();

  dmem_responder #(.MEM_WORDS(512), .LATENCY(LAT)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 32'd1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every response or exception pulse consumes one scoreboard entry.
  always @(negedge clk_i) begin
    logic [2:0] k;
    logic       ev;
    exp_t       e;
    ev = 1'b1;
    k  = K_RESP;
    if (bus.dmem_resp_valid_o)          k = K_RESP;
    else if (bus.dmem_xcpt_ma_ld_o)     k = K_MALD;
    else if (bus.dmem_xcpt_ma_st_o)     k = K_MAST;
    else if (bus.dmem_xcpt_pf_ld_o)     k = K_PFLD;
    else if (bus.dmem_xcpt_pf_st_o)     k = K_PFST;
    else if (bus.dmem_resp_bits_nack_o) k = K_NACK;
    else ev = 1'b0;
    if (ev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("event_kind", 64'(k), 64'(e.kind));
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        if (k == K_RESP) begin
          chk("resp_data", bus.dmem_resp_bits_data_o, e.data);
          chk("resp_tag", 64'(bus.dmem_resp_bits_tag_o), 64'(e.tag));
        end
      end
    end
  end

  task automatic drive_idle();
    bus.mem_req_valid_i         = 1'b0;
    bus.mem_req_cmd_i           = 5'd0;
    bus.mem_op_type_i           = 4'd0;
    bus.mem_req_bits_addr_i     = 40'd0;
    bus.mem_req_bits_data_i     = 64'd0;
    bus.mem_req_bits_tag_i      = 8'd0;
    bus.mem_req_bits_kill_i     = 1'b0;
    bus.mem_req_invalidate_lr_i = 1'b0;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!bus.dmem_req_ready_o && g < 50) begin
      @(posedge clk_i); #1;
      g++;
    end
    if (!bus.dmem_req_ready_o) begin
      checks++;
      errs++;
      $display("FAIL ready_timeout: got ready 0 expected 1");
    end
  endtask

  // Presents one request and leaves it exactly one cycle; returns accept cycle.
  task automatic present(input logic [4:0] cmd, input logic [3:0] op, input logic [39:0] addr,
                         input logic [63:0] data, output logic [31:0] acc);
    wait_ready();
    bus.mem_req_valid_i     = 1'b1;
    bus.mem_req_cmd_i       = cmd;
    bus.mem_op_type_i       = op;
    bus.mem_req_bits_addr_i = addr;
    bus.mem_req_bits_data_i = data;
    bus.mem_req_bits_tag_i  = next_tag;
    @(posedge clk_i); #1;
    bus.mem_req_valid_i = 1'b0;
    acc = cyc;
  endtask

  task automatic issue(input string nm, input logic [4:0] cmd, input logic [3:0] op,
                       input logic [39:0] addr, input logic [63:0] data,
                       input logic [2:0] kind, input logic [63:0] edata, input int elow);
    logic [31:0] acc;
    exp_t        e;
    int          low;
    present(cmd, op, addr, data, acc);
    e.kind = kind;
    e.data = edata;
    e.tag  = next_tag;
    e.cyc  = (kind == K_RESP) ? acc + 32'(LAT - 1) : acc;
    sb_q.push_back(e);
    next_tag = next_tag + 8'd1;
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (bus.dmem_req_ready_o) break;
      low++;
    end
    chk({nm, "_ready_low"}, 64'(low), 64'(elow));
    @(posedge clk_i); #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, 64'(bus.dmem_req_ready_o), 64'd1);
    chk({nm, "_valid"}, 64'(bus.dmem_resp_valid_o), 64'd0);
    chk({nm, "_data"}, bus.dmem_resp_bits_data_o, 64'd0);
    chk({nm, "_tag"}, 64'(bus.dmem_resp_bits_tag_o), 64'd0);
    chk({nm, "_xcpt"}, 64'({bus.dmem_xcpt_ma_ld_o, bus.dmem_xcpt_ma_st_o, bus.dmem_xcpt_pf_ld_o,
                            bus.dmem_xcpt_pf_st_o, bus.dmem_resp_bits_nack_o,
                            bus.dmem_resp_bits_replay_o}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] acc;
    drive_idle();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_reset_outputs("reset");
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Basic dword store/load and sub-word extraction.
    issue("sd_40",   5'd1, 4'd3, 40'h40, 64'h1122334455667788, K_RESP, 64'h0, 2);
    issue("ld_40",   5'd0, 4'd3, 40'h40, 64'h0, K_RESP, 64'h1122334455667788, 2);
    issue("lbu_47",  5'd0, 4'd4, 40'h47, 64'h0, K_RESP, 64'h11, 2);
    issue("lh_46",   5'd0, 4'd1, 40'h46, 64'h0, K_RESP, 64'h1122, 2);
    issue("lw_44",   5'd0, 4'd2, 40'h44, 64'h0, K_RESP, 64'h11223344, 2);
    issue("sb_50",   5'd1, 4'd0, 40'h50, 64'h80, K_RESP, 64'h0, 2);
    issue("lb_50",   5'd0, 4'd0, 40'h50, 64'h0, K_RESP, 64'hFFFFFFFFFFFFFF80, 2);
    issue("lbu_50",  5'd0, 4'd4, 40'h50, 64'h0, K_RESP, 64'h80, 2);

    // Exceptions and unsupported commands.
    issue("sd_0",    5'd1, 4'd3, 40'h0, 64'hA5A5A5A5A5A5A5A5, K_RESP, 64'h0, 2);
    issue("lw_42",   5'd0, 4'd2, 40'h42, 64'h0, K_MALD, 64'h0, 1);
    issue("sd_1000", 5'd1, 4'd3, 40'h1000, 64'hDEAD, K_PFST, 64'h0, 1);
    issue("ld_0",    5'd0, 4'd3, 40'h0, 64'h0, K_RESP, 64'hA5A5A5A5A5A5A5A5, 2);
    issue("sw_1002", 5'd1, 4'd2, 40'h1002, 64'h1, K_MAST, 64'h0, 1);
    issue("ld_1000", 5'd0, 4'd3, 40'h1000, 64'h0, K_PFLD, 64'h0, 1);
    issue("cmd_2",   5'd2, 4'd3, 40'h40, 64'h0, K_NACK, 64'h0, 1);
    issue("amo_b",   5'd8, 4'd0, 40'h40, 64'h1, K_NACK, 64'h0, 1);

    // LR/SC reservation.
    issue("lr_40",   5'd6, 4'd3, 40'h40, 64'h0, K_RESP, 64'h1122334455667788, 2);
    issue("sc_ok",   5'd7, 4'd3, 40'h40, 64'h99, K_RESP, 64'h0, 2);
    issue("ld_sc",   5'd0, 4'd3, 40'h40, 64'h0, K_RESP, 64'h99, 2);
    issue("sc_again",5'd7, 4'd3, 40'h40, 64'h55, K_RESP, 64'h1, 2);
    issue("lr_40b",  5'd6, 4'd3, 40'h40, 64'h0, K_RESP, 64'h99, 2);
    bus.mem_req_invalidate_lr_i = 1'b1;
    @(posedge clk_i); #1;
    bus.mem_req_invalidate_lr_i = 1'b0;
    issue("sc_inv",  5'd7, 4'd3, 40'h40, 64'h77, K_RESP, 64'h1, 2);
    issue("ld_inv",  5'd0, 4'd3, 40'h40, 64'h0, K_RESP, 64'h99, 2);

    // AMOs on a word.
    issue("sw_48",   5'd1, 4'd2, 40'h48, 64'h7FFFFFFF, K_RESP, 64'h0, 2);
    issue("amoadd",  5'd8, 4'd2, 40'h48, 64'h1, K_RESP, 64'h7FFFFFFF, 2);
    issue("lwu_48",  5'd0, 4'd6, 40'h48, 64'h0, K_RESP, 64'h80000000, 2);
    issue("amomaxu", 5'd15, 4'd2, 40'h48, 64'h0, K_RESP, 64'hFFFFFFFF80000000, 2);
    issue("lwu_48b", 5'd0, 4'd6, 40'h48, 64'h0, K_RESP, 64'h80000000, 2);
    issue("amomin",  5'd12, 4'd2, 40'h48, 64'h1, K_RESP, 64'hFFFFFFFF80000000, 2);
    issue("lwu_48c", 5'd0, 4'd6, 40'h48, 64'h0, K_RESP, 64'h80000000, 2);

    // Kill in the WAIT cycle: nothing must come back and memory must keep old data.
    present(5'd1, 4'd3, 40'h40, 64'hBAD, acc);
    bus.mem_req_bits_kill_i = 1'b1;
    @(posedge clk_i); #1;
    bus.mem_req_bits_kill_i = 1'b0;
    chk("kill_ready", 64'(bus.dmem_req_ready_o), 64'd1);
    next_tag = next_tag + 8'd1;
    issue("ld_kill", 5'd0, 4'd3, 40'h40, 64'h0, K_RESP, 64'h99, 2);

    // Reset in the WAIT cycle discards the store.
    present(5'd1, 4'd3, 40'h40, 64'hBAD2, acc);
    rstn_i = 1'b0;
    @(negedge clk_i);
    chk_reset_outputs("midreset");
    @(negedge clk_i);
    chk_reset_outputs("midreset2");
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    next_tag = next_tag + 8'd1;
    issue("ld_rst",  5'd0, 4'd3, 40'h40, 64'h0, K_RESP, 64'h99, 2);

    repeat (5) @(posedge clk_i);
    chk("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
